// File: rtl/spectrum_pkg.sv
// Shared types and default geometry for the spectrum pipeline image path.
package spectrum_pkg;

   localparam int unsigned IMG_ROWS = 4;
   localparam int unsigned IMG_COLS = 4;
   localparam int unsigned WIDTH    = 32;

   typedef logic signed [WIDTH-1:0] pixel_t;
   typedef pixel_t [IMG_ROWS-1:0][IMG_COLS-1:0] image_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } load_state_t;

   // Index width that stays at least one bit for a single-entry dimension.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Down-counting row/column address pair; column wraps and borrows from row.
module pixel_addr_counter
   import spectrum_pkg::*;
#(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        clear,
   output logic [idx_width(ROWS)-1:0]  row,
   output logic [idx_width(COLS)-1:0]  col,
   output logic                        last
);

   localparam int unsigned RW = idx_width(ROWS);
   localparam int unsigned CW = idx_width(COLS);
   localparam logic [RW-1:0] ROW_TOP = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_TOP = CW'(COLS - 1);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = ROW_TOP;
         col_d = COL_TOP;
      end else if (en) begin
         if (col_q == '0) begin
            col_d = COL_TOP;
            row_d = (row_q == '0) ? ROW_TOP : row_q - RW'(1);
         end else begin
            col_d = col_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         row_q <= ROW_TOP;
         col_q <= COL_TOP;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign last = (row_q == '0) && (col_q == '0);

endmodule

// File: rtl/memory_import.sv
// Streaming frame loader: assembles one pixel per accept into a packed image
// and hands each complete frame to the consumer over a valid/ack handshake.
module memory_import #(
   parameter int unsigned IMG_ROWS = spectrum_pkg::IMG_ROWS,
   parameter int unsigned IMG_COLS = spectrum_pkg::IMG_COLS,
   parameter int unsigned WIDTH    = spectrum_pkg::WIDTH
) (
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic [WIDTH-1:0]                             in_data,
   input  logic                                         in_valid,
   input  logic                                         in_last,
   output logic                                         in_ready,
   output logic [IMG_ROWS-1:0][IMG_COLS-1:0][WIDTH-1:0] image,
   output logic                                         image_valid,
   input  logic                                         image_ack,
   output logic [$clog2(IMG_ROWS*IMG_COLS+1)-1:0]       fill_count,
   output logic                                         frame_err
);

   import spectrum_pkg::*;

   localparam int unsigned N   = IMG_ROWS * IMG_COLS;
   localparam int unsigned FCW = $clog2(N + 1);
   localparam int unsigned RW  = idx_width(IMG_ROWS);
   localparam int unsigned CW  = idx_width(IMG_COLS);

   load_state_t                                 state_q, state_d;
   logic [IMG_ROWS-1:0][IMG_COLS-1:0][WIDTH-1:0] image_q;
   logic [FCW-1:0]                              fill_q, fill_d;
   logic                                        err_q, err_d;
   logic                                        accept;
   logic                                        ctr_clear;
   logic                                        addr_last;
   logic [RW-1:0]                               row;
   logic [CW-1:0]                               col;

   pixel_addr_counter #(
      .ROWS (IMG_ROWS),
      .COLS (IMG_COLS)
   ) u_addr (
      .clock (clock),
      .reset (reset),
      .en    (accept),
      .clear (ctr_clear),
      .row   (row),
      .col   (col),
      .last  (addr_last)
   );

   // Framing: the address counter, not in_last, decides where a frame ends.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      err_d     = err_q;
      accept    = 1'b0;
      ctr_clear = 1'b0;
      case (state_q)
         FILL: begin
            accept = in_valid;
            if (in_valid) begin
               if (addr_last) begin
                  state_d   = FULL;
                  fill_d    = '0;
                  ctr_clear = 1'b1;
                  if (!in_last) err_d = 1'b1;
               end else if (in_last) begin
                  fill_d    = '0;
                  ctr_clear = 1'b1;
                  err_d     = 1'b1;
               end else begin
                  fill_d = fill_q + FCW'(1);
               end
            end
         end
         FULL: begin
            if (image_ack) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FILL;
         fill_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         image_q <= '0;
      end else if (accept) begin
         image_q[row][col] <= in_data;
      end
   end

   assign in_ready    = (state_q == FILL);
   assign image_valid = (state_q == FULL);
   assign image       = image_q;
   assign fill_count  = fill_q;
   assign frame_err   = err_q;

endmodule

// File: tb/tb_memory_import.sv
// Self-checking bench for memory_import: directed table, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_memory_import;

   localparam int unsigned R   = 4;
   localparam int unsigned C   = 4;
   localparam int unsigned W   = 32;
   localparam int unsigned N   = R * C;
   localparam int unsigned FCW = $clog2(N + 1);

   typedef logic [R-1:0][C-1:0][W-1:0] img_t;

   typedef struct {
      bit          rst;
      bit          v;
      bit          l;
      bit          a;
      logic [31:0] d;
      bit          e_ready;
      bit          e_valid;
      int          e_fill;
      bit          e_err;
   } vec_t;

   logic           clock = 1'b0;
   logic           reset;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_last;
   logic           in_ready;
   img_t           image;
   logic           image_valid;
   logic           image_ack;
   logic [FCW-1:0] fill_count;
   logic           frame_err;

   always #5 clock = ~clock;

   memory_import #(
      .IMG_ROWS (R),
      .IMG_COLS (C),
      .WIDTH    (W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .image       (image),
      .image_valid (image_valid),
      .image_ack   (image_ack),
      .fill_count  (fill_count),
      .frame_err   (frame_err)
   );

   // Reference model: pixel grid, word index within frame, full flag, error flag.
   logic [W-1:0] m_img [R][C];
   int           m_k;
   bit           m_full;
   bit           m_err;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_img(input string name, input img_t act, input img_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic img_t model_image();
      img_t res;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            res[r][c] = m_img[r][c];
      return res;
   endfunction

   function automatic void model_step(input bit rst, input bit v, input bit l,
                                      input bit a, input logic [W-1:0] d);
      if (rst) begin
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
               m_img[r][c] = '0;
         m_k = 0; m_full = 0; m_err = 0;
      end else if (!m_full && v) begin
         m_img[R-1 - m_k / C][C-1 - m_k % C] = d;
         if (m_k == N-1) begin
            if (!l) m_err = 1;
            m_full = 1;
            m_k = 0;
         end else if (l) begin
            m_err = 1;
            m_k = 0;
         end else begin
            m_k++;
         end
      end else if (m_full && a) begin
         m_full = 0;
      end
   endfunction

   // One clock: drive, model the edge, then compare every output to the model.
   task automatic cycle(input bit rst, input bit v, input bit l, input bit a,
                        input logic [W-1:0] d);
      reset = rst; in_valid = v; in_last = l; image_ack = a; in_data = d;
      @(posedge clock);
      model_step(rst, v, l, a, d);
      #1;
      chk("model_ready", in_ready, !m_full);
      chk("model_valid", image_valid, m_full);
      chk("model_fill", fill_count, m_k);
      chk("model_err", frame_err, m_err);
      chk_img("model_image", image, model_image());
   endtask

   function automatic vec_t mkv(input bit rst, input bit v, input bit l, input bit a,
                                input logic [31:0] d, input bit er, input bit ev,
                                input int ef, input bit ee);
      vec_t x;
      x.rst = rst; x.v = v; x.l = l; x.a = a; x.d = d;
      x.e_ready = er; x.e_valid = ev; x.e_fill = ef; x.e_err = ee;
      return x;
   endfunction

   localparam logic [W-1:0] M = 32'hFFFF_FFFF;
   localparam logic [W-1:0] P = 32'h0000_0001;

   initial begin
      vec_t         tbl [18];
      logic [W-1:0] pat [16];
      img_t         lit;
      int           n;
      bit           v, l, a, rst;

      reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; image_ack = 1'b0; in_data = '0;
      m_k = 0; m_full = 0; m_err = 0;

      pat = '{M, M, M, M, M, P, P, M, M, P, P, M, M, M, M, M};
      lit = {M, M, M, M, M, P, P, M, M, P, P, M, M, M, M, M};

      // Basic load table: reset, 16 words, then one refused word while full.
      tbl[0] = mkv(1, 0, 0, 0, 32'd0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++)
         tbl[i+1] = mkv(0, 1, i == 15, 0, pat[i], i != 15, i == 15,
                        (i == 15) ? 0 : i + 1, 0);
      tbl[17] = mkv(0, 1, 0, 0, 32'd7, 0, 1, 0, 0);

      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].a, tbl[i].d);
         chk("tbl_ready", in_ready, tbl[i].e_ready);
         chk("tbl_valid", image_valid, tbl[i].e_valid);
         chk("tbl_fill", fill_count, tbl[i].e_fill);
         chk("tbl_err", frame_err, tbl[i].e_err);
      end
      chk_img("basic_image", image, lit);

      // Backpressure: valid held, no ack for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 0, 0, $urandom);
         chk("bp_ready", in_ready, 0);
         chk_img("bp_image", image, lit);
      end
      cycle(0, 0, 0, 1, '0);
      chk("ack_ready", in_ready, 1);
      cycle(0, 1, 0, 0, 32'd100);
      chk("ack_next_word", image[3][3], 100);
      chk("ack_next_fill", fill_count, 1);

      // Bursty input, words 0..15 on alternate cycles.
      cycle(1, 0, 0, 0, '0);
      n = 0;
      for (int cyc = 0; cyc < 32; cyc++) begin
         v = (cyc % 2) == 0;
         cycle(0, v, v && n == 15, 0, v ? n : $urandom);
         if (v) n++;
         chk("burst_fill", fill_count, n % 16);
      end
      chk("burst_first", image[3][3], 0);
      chk("burst_last", image[0][0], 15);
      chk("burst_valid", image_valid, 1);

      // Early last on the fifth word, then a clean frame.
      cycle(1, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) cycle(0, 1, i == 4, 0, 50 + i);
      chk("early_err", frame_err, 1);
      chk("early_fill", fill_count, 0);
      chk("early_valid", image_valid, 0);
      cycle(0, 0, 0, 1, '0);
      chk("early_idle_valid", image_valid, 0);
      for (int i = 0; i < 16; i++) cycle(0, 1, i == 15, 0, 200 + i);
      chk("early_then_valid", image_valid, 1);
      chk("early_then_err", frame_err, 1);
      chk("early_then_corner", image[0][0], 215);

      // Missing last.
      cycle(1, 0, 0, 0, '0);
      for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, $urandom);
      chk("miss_valid", image_valid, 1);
      chk("miss_err", frame_err, 1);

      // Mid-frame reset with a word presented during reset.
      cycle(1, 0, 0, 0, '0);
      for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 300 + i);
      cycle(1, 1, 0, 0, 32'd99);
      chk("mrst_fill", fill_count, 0);
      chk("mrst_ready", in_ready, 1);
      chk("mrst_valid", image_valid, 0);
      chk("mrst_err", frame_err, 0);
      chk_img("mrst_image", image, '0);
      for (int i = 0; i < 16; i++) cycle(0, 1, i == 15, 0, 400 + i);
      chk("mrst_frame_valid", image_valid, 1);
      chk("mrst_frame_err", frame_err, 0);
      chk("mrst_frame_first", image[3][3], 400);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(0, 99) == 0;
         v   = $urandom_range(0, 9) < 7;
         a   = $urandom_range(0, 9) < 3;
         if (m_k == N-1) l = $urandom_range(0, 3) != 0;
         else            l = $urandom_range(0, 19) == 0;
         cycle(rst, v, l, a, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
